axi_lite_arb2: RTL and testbench

Two-master AXI4-Lite arbiter sharing the single DDR-side AXI4-Lite port between the AHB-Lite bridge (master 0) and the image-capture write/read DMA (master 1). Read and write directions are arbitrated independently, round-robin, with one outstanding transaction per direction. Sits between the bridge/DMA and the memory controller slave port.

---
 rtl/axi_arb_pkg.sv | 22 ++
 rtl/rr_arb2.sv | 16 +
 rtl/axi_lite_arb2.sv | 197 +++++++++++++++++++
 tb/tb_axi_lite_arb2.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_arb_pkg.sv
// rtl/axi_arb_pkg.sv - shared types for the two-master AXI4-Lite arbiter
package axi_arb_pkg;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ADDR = 2'd1,
    W_DATA = 2'd2,
    W_RESP = 2'd3
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rd_state_t;

  typedef logic mst_idx_t;

  localparam mst_idx_t   MST_BRIDGE    = 1'b0;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin picker; ptr names the master that wins a tie
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic       grant,
  output logic       valid
);

  always_comb begin
    valid = |req;
    grant = 1'b0;
    if (req == 2'b11) grant = ptr;
    else if (req[1])  grant = 1'b1;
  end

endmodule

// File: rtl/axi_lite_arb2.sv
// rtl/axi_lite_arb2.sv - two-master AXI4-Lite arbiter, independent round-robin read and write paths
module axi_lite_arb2
  import axi_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_awaddr,
  input  logic                m0_awvalid,
  output logic                m0_awready,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  input  logic                m0_wvalid,
  output logic                m0_wready,
  output logic [1:0]          m0_bresp,
  output logic                m0_bvalid,
  input  logic                m0_bready,
  input  logic [ADDR_W-1:0]   m0_araddr,
  input  logic                m0_arvalid,
  output logic                m0_arready,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic [1:0]          m0_rresp,
  output logic                m0_rvalid,
  input  logic                m0_rready,
  input  logic [ADDR_W-1:0]   m1_awaddr,
  input  logic                m1_awvalid,
  output logic                m1_awready,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  input  logic                m1_wvalid,
  output logic                m1_wready,
  output logic [1:0]          m1_bresp,
  output logic                m1_bvalid,
  input  logic                m1_bready,
  input  logic [ADDR_W-1:0]   m1_araddr,
  input  logic                m1_arvalid,
  output logic                m1_arready,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic [1:0]          m1_rresp,
  output logic                m1_rvalid,
  input  logic                m1_rready,
  output logic [ADDR_W-1:0]   s_awaddr,
  output logic                s_awvalid,
  input  logic                s_awready,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  output logic                s_wvalid,
  input  logic                s_wready,
  input  logic [1:0]          s_bresp,
  input  logic                s_bvalid,
  output logic                s_bready,
  output logic [ADDR_W-1:0]   s_araddr,
  output logic                s_arvalid,
  input  logic                s_arready,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic [1:0]          s_rresp,
  input  logic                s_rvalid,
  output logic                s_rready,
  output logic                wr_owner,
  output logic                rd_owner
);

  wr_state_t wr_state, wr_state_nxt;
  rd_state_t rd_state, rd_state_nxt;
  mst_idx_t  wr_ptr, rd_ptr, wr_pick, rd_pick;
  logic      wr_req, rd_req;

  rr_arb2 u_wr_arb (.req({m1_awvalid, m0_awvalid}), .ptr(wr_ptr), .grant(wr_pick), .valid(wr_req));
  rr_arb2 u_rd_arb (.req({m1_arvalid, m0_arvalid}), .ptr(rd_ptr), .grant(rd_pick), .valid(rd_req));

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_state <= W_IDLE;
      rd_state <= R_IDLE;
      wr_owner <= MST_BRIDGE;
      rd_owner <= MST_BRIDGE;
      wr_ptr   <= MST_BRIDGE;
      rd_ptr   <= MST_BRIDGE;
    end else begin
      wr_state <= wr_state_nxt;
      rd_state <= rd_state_nxt;
      if (wr_state == W_IDLE && wr_req) wr_owner <= wr_pick;
      if (rd_state == R_IDLE && rd_req) rd_owner <= rd_pick;
      // The master just served loses the next tie.
      if (wr_state == W_RESP && s_bvalid && s_bready) wr_ptr <= ~wr_owner;
      if (rd_state == R_DATA && s_rvalid && s_rready) rd_ptr <= ~rd_owner;
    end
  end

  logic [ADDR_W-1:0]   sel_awaddr, sel_araddr;
  logic [DATA_W-1:0]   sel_wdata;
  logic [DATA_W/8-1:0] sel_wstrb;
  logic                sel_awvalid, sel_wvalid, sel_bready, sel_arvalid, sel_rready;

  always_comb begin
    sel_awaddr  = wr_owner ? m1_awaddr  : m0_awaddr;
    sel_awvalid = wr_owner ? m1_awvalid : m0_awvalid;
    sel_wdata   = wr_owner ? m1_wdata   : m0_wdata;
    sel_wstrb   = wr_owner ? m1_wstrb   : m0_wstrb;
    sel_wvalid  = wr_owner ? m1_wvalid  : m0_wvalid;
    sel_bready  = wr_owner ? m1_bready  : m0_bready;
    sel_araddr  = rd_owner ? m1_araddr  : m0_araddr;
    sel_arvalid = rd_owner ? m1_arvalid : m0_arvalid;
    sel_rready  = rd_owner ? m1_rready  : m0_rready;
  end

  // Outputs are gated by phase, so idle or reset leaves every output at zero.
  always_comb begin
    wr_state_nxt = wr_state;
    s_awaddr     = '0;
    s_awvalid    = 1'b0;
    s_wdata      = '0;
    s_wstrb      = '0;
    s_wvalid     = 1'b0;
    s_bready     = 1'b0;
    m0_awready   = 1'b0;
    m1_awready   = 1'b0;
    m0_wready    = 1'b0;
    m1_wready    = 1'b0;
    m0_bvalid    = 1'b0;
    m1_bvalid    = 1'b0;
    m0_bresp     = AXI_RESP_OKAY;
    m1_bresp     = AXI_RESP_OKAY;
    case (wr_state)
      W_IDLE: if (wr_req) wr_state_nxt = W_ADDR;
      W_ADDR: begin
        s_awaddr  = sel_awaddr;
        s_awvalid = sel_awvalid;
        if (wr_owner) m1_awready = s_awready;
        else          m0_awready = s_awready;
        if (sel_awvalid && s_awready) wr_state_nxt = W_DATA;
      end
      W_DATA: begin
        s_wdata  = sel_wdata;
        s_wstrb  = sel_wstrb;
        s_wvalid = sel_wvalid;
        if (wr_owner) m1_wready = s_wready;
        else          m0_wready = s_wready;
        if (sel_wvalid && s_wready) wr_state_nxt = W_RESP;
      end
      W_RESP: begin
        s_bready = sel_bready;
        if (wr_owner) begin
          m1_bvalid = s_bvalid;
          m1_bresp  = s_bresp;
        end else begin
          m0_bvalid = s_bvalid;
          m0_bresp  = s_bresp;
        end
        if (s_bvalid && sel_bready) wr_state_nxt = W_IDLE;
      end
      default: wr_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    rd_state_nxt = rd_state;
    s_araddr     = '0;
    s_arvalid    = 1'b0;
    s_rready     = 1'b0;
    m0_arready   = 1'b0;
    m1_arready   = 1'b0;
    m0_rvalid    = 1'b0;
    m1_rvalid    = 1'b0;
    m0_rdata     = '0;
    m1_rdata     = '0;
    m0_rresp     = AXI_RESP_OKAY;
    m1_rresp     = AXI_RESP_OKAY;
    case (rd_state)
      R_IDLE: if (rd_req) rd_state_nxt = R_ADDR;
      R_ADDR: begin
        s_araddr  = sel_araddr;
        s_arvalid = sel_arvalid;
        if (rd_owner) m1_arready = s_arready;
        else          m0_arready = s_arready;
        if (sel_arvalid && s_arready) rd_state_nxt = R_DATA;
      end
      R_DATA: begin
        s_rready = sel_rready;
        if (rd_owner) begin
          m1_rvalid = s_rvalid;
          m1_rdata  = s_rdata;
          m1_rresp  = s_rresp;
        end else begin
          m0_rvalid = s_rvalid;
          m0_rdata  = s_rdata;
          m0_rresp  = s_rresp;
        end
        if (s_rvalid && sel_rready) rd_state_nxt = R_IDLE;
      end
      default: rd_state_nxt = R_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_lite_arb2.sv
// tb/tb_axi_lite_arb2.sv - scoreboard bench for axi_lite_arb2 with a responsive slave model
module tb_axi_lite_arb2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] awaddr_i [2];
  logic [31:0] wdata_i  [2];
  logic [3:0]  wstrb_i  [2];
  logic [31:0] araddr_i [2];
  logic        awvalid_i[2];
  logic        wvalid_i [2];
  logic        bready_i [2];
  logic        arvalid_i[2];
  logic        rready_i [2];

  logic        m0_awready, m0_wready, m0_bvalid, m0_arready, m0_rvalid;
  logic        m1_awready, m1_wready, m1_bvalid, m1_arready, m1_rvalid;
  logic [1:0]  m0_bresp, m1_bresp, m0_rresp, m1_rresp;
  logic [31:0] m0_rdata, m1_rdata;

  logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
  logic [3:0]  s_wstrb;
  logic        s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
  logic        s_awready, s_wready, s_bvalid, s_rvalid, s_arready;
  logic [1:0]  s_bresp, s_rresp;
  logic        wr_owner, rd_owner;
  int          ar_stall = 0;

  assign s_arready = (ar_stall == 0);

  axi_lite_arb2 #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .m0_awaddr(awaddr_i[0]), .m0_awvalid(awvalid_i[0]), .m0_awready(m0_awready),
    .m0_wdata(wdata_i[0]), .m0_wstrb(wstrb_i[0]), .m0_wvalid(wvalid_i[0]), .m0_wready(m0_wready),
    .m0_bresp(m0_bresp), .m0_bvalid(m0_bvalid), .m0_bready(bready_i[0]),
    .m0_araddr(araddr_i[0]), .m0_arvalid(arvalid_i[0]), .m0_arready(m0_arready),
    .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(rready_i[0]),
    .m1_awaddr(awaddr_i[1]), .m1_awvalid(awvalid_i[1]), .m1_awready(m1_awready),
    .m1_wdata(wdata_i[1]), .m1_wstrb(wstrb_i[1]), .m1_wvalid(wvalid_i[1]), .m1_wready(m1_wready),
    .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid), .m1_bready(bready_i[1]),
    .m1_araddr(araddr_i[1]), .m1_arvalid(arvalid_i[1]), .m1_arready(m1_arready),
    .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(rready_i[1]),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .wr_owner(wr_owner), .rd_owner(rd_owner)
  );

  logic any_out;
  assign any_out = |{m0_awready, m0_wready, m0_bresp, m0_bvalid, m0_arready, m0_rdata, m0_rresp, m0_rvalid,
                     m1_awready, m1_wready, m1_bresp, m1_bvalid, m1_arready, m1_rdata, m1_rresp, m1_rvalid,
                     s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
                     s_araddr, s_arvalid, s_rready, wr_owner, rd_owner};

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [31:0] aw_exp[$];
  logic [35:0] w_exp[$];
  logic [31:0] ar_exp[$];
  logic [33:0] rsp_q[$];

  // Slave model: handshakes decided from stable negedge values, responses applied after the edge.
  initial begin
    bit aw_hs, w_hs, b_hs, ar_hs, r_hs, stall_now;
    logic [33:0] rsp;
    s_awready = 1'b1; s_wready = 1'b1;
    s_bvalid = 1'b0; s_bresp = 2'b00;
    s_rvalid = 1'b0; s_rdata = '0; s_rresp = 2'b00;
    forever begin
      @(negedge clk);
      aw_hs = s_awvalid && s_awready;
      w_hs  = s_wvalid && s_wready;
      b_hs  = s_bvalid && s_bready;
      ar_hs = s_arvalid && s_arready;
      r_hs  = s_rvalid && s_rready;
      stall_now = s_arvalid && !s_arready;
      if (!reset) begin
        if (aw_hs) begin
          if (aw_exp.size() > 0) check("s_awaddr", s_awaddr, aw_exp.pop_front());
          else check("aw_unexpected", aw_hs, 0);
        end
        if (w_hs) begin
          if (w_exp.size() > 0) check("s_wstrb_wdata", {s_wstrb, s_wdata}, w_exp.pop_front());
          else check("w_unexpected", w_hs, 0);
        end
        if (ar_hs) begin
          if (ar_exp.size() > 0) check("s_araddr", s_araddr, ar_exp.pop_front());
          else check("ar_unexpected", ar_hs, 0);
        end
        if (stall_now && ar_exp.size() > 0) begin
          check("s_araddr_stall", s_araddr, ar_exp[0]);
          check("arready_stall", {m0_arready, m1_arready}, 0);
        end
      end
      @(posedge clk); #1;
      if (reset) begin
        s_bvalid = 1'b0; s_bresp = 2'b00;
        s_rvalid = 1'b0; s_rdata = '0; s_rresp = 2'b00;
      end else begin
        if (b_hs) s_bvalid = 1'b0;
        if (w_hs) begin s_bvalid = 1'b1; s_bresp = 2'b00; end
        if (r_hs) begin s_rvalid = 1'b0; s_rdata = '0; s_rresp = 2'b00; end
        if (ar_hs) begin
          rsp = (rsp_q.size() > 0) ? rsp_q.pop_front() : 34'h0;
          s_rvalid = 1'b1; s_rresp = rsp[33:32]; s_rdata = rsp[31:0];
        end
        if (stall_now && ar_stall > 0) ar_stall--;
      end
    end
  end

  // The master not holding a direction must see all of that direction's outputs at zero.
  always @(negedge clk) begin
    if (!reset) begin
      if (wr_owner) check("m0_wr_quiet", {m0_awready, m0_wready, m0_bvalid, m0_bresp}, 0);
      else          check("m1_wr_quiet", {m1_awready, m1_wready, m1_bvalid, m1_bresp}, 0);
      if (rd_owner) check("m0_rd_quiet", {m0_arready, m0_rvalid, m0_rresp, m0_rdata}, 0);
      else          check("m1_rd_quiet", {m1_arready, m1_rvalid, m1_rresp, m1_rdata}, 0);
    end
  end

  function automatic logic mo(input int m, input int which);
    case (which)
      0:       return m ? m1_awready : m0_awready;
      1:       return m ? m1_wready  : m0_wready;
      2:       return m ? m1_bvalid  : m0_bvalid;
      3:       return m ? m1_arready : m0_arready;
      default: return m ? m1_rvalid  : m0_rvalid;
    endcase
  endfunction

  task automatic wait_hs(input int m, input int which, inout int cyc);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      cyc++;
      if (mo(m, which)) return;
    end
    check("hs_timeout", mo(m, which), 1);
  endtask

  task automatic do_write(input int m, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output int cyc);
    cyc = 0;
    awaddr_i[m] = addr; awvalid_i[m] = 1'b1;
    wait_hs(m, 0, cyc);
    @(posedge clk); #1;
    awvalid_i[m] = 1'b0; wdata_i[m] = data; wstrb_i[m] = strb; wvalid_i[m] = 1'b1;
    wait_hs(m, 1, cyc);
    @(posedge clk); #1;
    wvalid_i[m] = 1'b0; bready_i[m] = 1'b1;
    wait_hs(m, 2, cyc);
    check("bresp", m ? m1_bresp : m0_bresp, 2'b00);
    @(posedge clk); #1;
    bready_i[m] = 1'b0;
  endtask

  task automatic do_read(input int m, input logic [31:0] addr, input logic [31:0] exp_data,
                         input logic [1:0] exp_resp, output int cyc);
    cyc = 0;
    araddr_i[m] = addr; arvalid_i[m] = 1'b1;
    wait_hs(m, 3, cyc);
    @(posedge clk); #1;
    arvalid_i[m] = 1'b0; rready_i[m] = 1'b1;
    wait_hs(m, 4, cyc);
    check("rdata", m ? m1_rdata : m0_rdata, exp_data);
    check("rresp", m ? m1_rresp : m0_rresp, exp_resp);
    @(posedge clk); #1;
    rready_i[m] = 1'b0;
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    aw_exp.delete(); w_exp.delete(); ar_exp.delete(); rsp_q.delete();
  endtask

  initial begin
    int c0, c1, cr;
    for (int m = 0; m < 2; m++) begin
      awaddr_i[m] = '0; wdata_i[m] = '0; wstrb_i[m] = '0; araddr_i[m] = '0;
      awvalid_i[m] = 1'b0; wvalid_i[m] = 1'b0; bready_i[m] = 1'b0;
      arvalid_i[m] = 1'b0; rready_i[m] = 1'b0;
    end
    repeat (3) @(negedge clk);
    check("reset_outs_zero", any_out, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Single bridge write with minimum latency.
    aw_exp.push_back(32'h0000_1000);
    w_exp.push_back({4'hF, 32'hDEAD_BEEF});
    do_write(0, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF, c0);
    check("write_cycles", c0, 4);

    // Collision after reset: pointer at m0, then m1 follows straight from IDLE.
    apply_reset();
    aw_exp.push_back(32'h1000_0000); w_exp.push_back({4'h3, 32'h0000_00A0});
    aw_exp.push_back(32'h1000_0100); w_exp.push_back({4'hC, 32'h0000_00A1});
    fork
      do_write(0, 32'h1000_0000, 32'h0000_00A0, 4'h3, c0);
      do_write(1, 32'h1000_0100, 32'h0000_00A1, 4'hC, c1);
    join
    check("collA_m0_cycles", c0, 4);
    check("collA_m1_cycles", c1, 8);

    // Lone m0 write moves the pointer to m1, so the next collision favours m1.
    aw_exp.push_back(32'h2000_0000); w_exp.push_back({4'hF, 32'h0000_00B0});
    do_write(0, 32'h2000_0000, 32'h0000_00B0, 4'hF, c0);
    aw_exp.push_back(32'h3000_0100); w_exp.push_back({4'h1, 32'h0000_00C1});
    aw_exp.push_back(32'h3000_0000); w_exp.push_back({4'h8, 32'h0000_00C0});
    fork
      do_write(0, 32'h3000_0000, 32'h0000_00C0, 4'h8, c0);
      do_write(1, 32'h3000_0100, 32'h0000_00C1, 4'h1, c1);
    join
    check("collB_m1_cycles", c1, 4);
    check("collB_m0_cycles", c0, 8);

    // Concurrent m1 read and m0 write.
    ar_exp.push_back(32'h0000_0100); rsp_q.push_back({2'b00, 32'hCAFE_0001});
    aw_exp.push_back(32'h0000_0200); w_exp.push_back({4'hF, 32'h5555_AAAA});
    fork
      do_read(1, 32'h0000_0100, 32'hCAFE_0001, 2'b00, cr);
      do_write(0, 32'h0000_0200, 32'h5555_AAAA, 4'hF, c0);
      begin
        repeat (2) @(negedge clk);
        check("conc_rd_owner", rd_owner, 1);
        check("conc_wr_owner", wr_owner, 0);
      end
    join
    check("conc_read_cycles", cr, 3);
    check("conc_write_cycles", c0, 4);

    // Slave stalls AR for five cycles.
    ar_stall = 5;
    ar_exp.push_back(32'h0000_0300); rsp_q.push_back({2'b00, 32'h0BAD_F00D});
    do_read(1, 32'h0000_0300, 32'h0BAD_F00D, 2'b00, cr);
    check("stall_read_cycles", cr, 8);

    // Error response forwarded untouched.
    ar_exp.push_back(32'h0000_0400); rsp_q.push_back({2'b10, 32'h1234_5678});
    do_read(0, 32'h0000_0400, 32'h1234_5678, 2'b10, cr);

    // Reset while m1 sits in W_DATA.
    aw_exp.push_back(32'h0000_0500);
    awaddr_i[1] = 32'h0000_0500; awvalid_i[1] = 1'b1;
    c1 = 0;
    wait_hs(1, 0, c1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("pre_reset_wr_owner", wr_owner, 1);
    @(negedge clk);
    check("mid_reset_outs_zero", any_out, 0);
    check("mid_reset_wr_owner", wr_owner, 0);
    @(posedge clk); #1;
    reset = 1'b0; awvalid_i[1] = 1'b0;
    aw_exp.delete(); w_exp.delete();
    aw_exp.push_back(32'h0000_0600); w_exp.push_back({4'h5, 32'h0F0F_0F0F});
    do_write(1, 32'h0000_0600, 32'h0F0F_0F0F, 4'h5, c1);
    check("post_reset_write_cycles", c1, 4);

    repeat (2) @(negedge clk);
    check("aw_queue_drained", aw_exp.size(), 0);
    check("w_queue_drained", w_exp.size(), 0);
    check("ar_queue_drained", ar_exp.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
